// File: rtl/wavelet_drv_pkg.sv
// Shared definitions for the wavelet stream driver.
//   - drv_state_t   : driver FSM states
//   - DEF_*         : default widths, channel count and strobe timing
//   - cnt_width()   : width of the timing down-counter, clog2(max(a,b,c)+1)
package wavelet_drv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        HIGH   = 3'd2,
        SETTLE = 3'd3,
        RESULT = 3'd4
    } drv_state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SEL_W      = 8;
    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_HIGH_CYC   = 4;
    localparam int DEF_SETTLE_CYC = 3;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wavelet_sample_fifo.sv
// Small synchronous sample FIFO.
//   clk, rst_n  : clock, async active-low reset (empties the FIFO)
//   push        : write push_data (caller guarantees not_full)
//   push_data   : sample to store
//   pop         : drop the head entry (caller guarantees !empty)
//   head        : oldest entry, read from the storage registers
//   empty       : no entries held
//   not_full    : registered "room for one more"; low while in reset
module wavelet_sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              not_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (AW+1)'(1);
    end

    // not_full is computed from the next occupancy so it is exact every
    // cycle; a push into a full FIFO is impossible even with a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            not_full <= (count_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/wavelet_stream_driver.sv
// Host-side driver for the wavelet_transform pin interface.
// Buffers samples, strobes each one into the wavelet block with a slow
// data clock, then sweeps the output-channel select and returns one
// captured result per channel.
//   clk, rst_n                 : clock, async active-low reset
//   i_sample_valid/i_sample    : sample stream in, o_sample_ready back
//   o_data_clk, o_value        : strobe and sample to the wavelet block
//   o_select_output_channel    : channel select to the wavelet block
//   i_multiplexed_wavelet_out  : selected channel value from the block
//   i_active                   : block active flag, reported per result
//   o_result_*                 : result stream (valid/ready, data, channel, active)
//   o_busy                     : high whenever the FSM is not in IDLE
//
// Both streams use valid/ready: a transfer happens on a clock edge where
// valid and ready are both high; the sender holds valid and its payload
// stable until that edge, and ready may change independently of valid.
module wavelet_stream_driver
    import wavelet_drv_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int HIGH_CYC   = DEF_HIGH_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_sample_ready,
    output logic              o_data_clk,
    output logic [DATA_W-1:0] o_value,
    output logic [SEL_W-1:0]  o_select_output_channel,
    input  logic [DATA_W-1:0] i_multiplexed_wavelet_out,
    input  logic              i_active,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic [DATA_W-1:0] o_result_data,
    output logic [SEL_W-1:0]  o_result_channel,
    output logic              o_result_active,
    output logic              o_busy
);

    localparam int CNT_W = cnt_width(SETUP_CYC, HIGH_CYC, SETTLE_CYC);

    // Counters load CYC-1 on entry and the state exits when they hit zero,
    // so each timed state lasts exactly CYC cycles.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD   = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

    drv_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  ch;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;

    assign fifo_push = i_sample_valid && o_sample_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    wavelet_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (i_sample),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .not_full  (o_sample_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            cnt                     <= '0;
            ch                      <= '0;
            o_data_clk              <= 1'b0;
            o_value                 <= '0;
            o_select_output_channel <= '0;
            o_result_valid          <= 1'b0;
            o_result_data           <= '0;
            o_result_channel        <= '0;
            o_result_active         <= 1'b0;
            o_busy                  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        // o_value only changes here, while the strobe is low.
                        o_value    <= fifo_head;
                        o_data_clk <= 1'b0;
                        cnt        <= SETUP_LOAD;
                        o_busy     <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        o_data_clk <= 1'b1;
                        cnt        <= HIGH_LOAD;
                        state      <= HIGH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        o_data_clk              <= 1'b0;
                        ch                      <= '0;
                        o_select_output_channel <= '0;
                        cnt                     <= SETTLE_LOAD;
                        state                   <= SETTLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        o_result_data    <= i_multiplexed_wavelet_out;
                        o_result_channel <= ch;
                        o_result_active  <= i_active;
                        o_result_valid   <= 1'b1;
                        state            <= RESULT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESULT: begin
                    // Result registers are untouched until the handshake.
                    if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        if (ch == LAST_CH) begin
                            o_select_output_channel <= '0;
                            o_busy                  <= 1'b0;
                            state                   <= IDLE;
                        end else begin
                            ch                      <= ch + SEL_W'(1);
                            o_select_output_channel <= ch + SEL_W'(1);
                            cnt                     <= SETTLE_LOAD;
                            state                   <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
